// File: rtl/vga_sync_gen_if.sv
// Pixel-side bundle between the VGA timer/frame buffer and vga_sync_gen.
// With TEST_PATTERN_EN defined the bundle also carries test_mode.
interface vga_sync_gen_if #(
  parameter int DATA_W = 8
);
  logic              enable;
  logic              pixel_clk;
  logic [9:0]        counter_in_col;
  logic [9:0]        counter_in_row;
  logic [19:0]       counter_in_addr;
  logic              rd_en;
  logic [19:0]       rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              hsync;
  logic              vsync;
  logic              blank_n;
  logic [DATA_W-1:0] rgb_out;
  logic              frame_start;
  logic              range_err;
`ifdef TEST_PATTERN_EN
  logic              test_mode;

  modport slave (
    input  enable, pixel_clk, counter_in_col, counter_in_row, counter_in_addr,
           rd_data, test_mode,
    output rd_en, rd_addr, hsync, vsync, blank_n, rgb_out, frame_start, range_err
  );
  modport master (
    output enable, pixel_clk, counter_in_col, counter_in_row, counter_in_addr,
           rd_data, test_mode,
    input  rd_en, rd_addr, hsync, vsync, blank_n, rgb_out, frame_start, range_err
  );
`else
  modport slave (
    input  enable, pixel_clk, counter_in_col, counter_in_row, counter_in_addr,
           rd_data,
    output rd_en, rd_addr, hsync, vsync, blank_n, rgb_out, frame_start, range_err
  );
  modport master (
    output enable, pixel_clk, counter_in_col, counter_in_row, counter_in_addr,
           rd_data,
    input  rd_en, rd_addr, hsync, vsync, blank_n, rgb_out, frame_start, range_err
  );
`endif
endinterface

// File: rtl/vga_sync_gen.sv
// VGA sync/blank decoder with frame-buffer read issue and read-latency compensation.
// Optional colour-bar generator enabled by defining TEST_PATTERN_EN.
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_TOTAL  = 525,
  parameter int MEM_LAT  = 2,
  parameter int DATA_W   = 8
) (
  input logic          clk,
  input logic          n_rst,
  vga_sync_gen_if.slave bus
);

  localparam int STAGES = MEM_LAT + 1;

  localparam logic [9:0] HA  = 10'(H_ACTIVE);
  localparam logic [9:0] HS0 = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS1 = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] HT  = 10'(H_TOTAL);
  localparam logic [9:0] VA  = 10'(V_ACTIVE);
  localparam logic [9:0] VS0 = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS1 = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] VT  = 10'(V_TOTAL);
`ifdef TEST_PATTERN_EN
  localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);
`endif

  typedef enum logic [1:0] {IDLE, SYNCING, ACTIVE} state_t;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       act;
    logic       first;
`ifdef TEST_PATTERN_EN
    logic       pat;
    logic [2:0] bar;
`endif
  } tap_t;

  function automatic tap_t idle_tap();
    tap_t t;
    t    = '0;
    t.hs = 1'b1;
    t.vs = 1'b1;
    return t;
  endfunction

  // Out-of-range counters decode as a blank pixel with both syncs inactive.
  function automatic tap_t decode_p0(input logic [9:0] col, input logic [9:0] row);
    tap_t t;
    logic in_rng;
    t       = idle_tap();
    in_rng  = (col < HT) && (row < VT);
    t.act   = in_rng && (col < HA) && (row < VA);
    t.hs    = !(in_rng && (col >= HS0) && (col < HS1));
    t.vs    = !(in_rng && (row >= VS0) && (row < VS1));
    t.first = (col == 10'd0) && (row == 10'd0);
`ifdef TEST_PATTERN_EN
    t.bar   = 3'(col / BAR_W);
`endif
    return t;
  endfunction

  function automatic logic [DATA_W-1:0] pixel_out(input tap_t t, input logic [DATA_W-1:0] mem);
    if (!t.act) return '0;
`ifdef TEST_PATTERN_EN
    if (t.pat) return DATA_W'({{3{t.bar[2]}}, {3{t.bar[1]}}, {2{t.bar[0]}}});
`endif
    return mem;
  endfunction

  state_t            r_state;
  tap_t              r_dl [STAGES];
  logic              r_hsync;
  logic              r_vsync;
  logic              r_blank_n;
  logic [DATA_W-1:0] r_rgb;
  logic              r_rd_en;
  logic [19:0]       r_rd_addr;
  logic              r_frame_start;
  logic              r_range_err;

  tap_t w_tap_p0;
  tap_t w_push_p0;
  tap_t w_tail;
  logic w_live;
  logic w_oor;
  logic w_rd_req;

  always_comb begin
    w_tap_p0  = decode_p0(bus.counter_in_col, bus.counter_in_row);
    w_oor     = (bus.counter_in_col >= HT) || (bus.counter_in_row >= VT);
    // The (0,0) strobe that ends SYNCING is already the first live pixel.
    w_live    = (r_state == ACTIVE) || ((r_state == SYNCING) && w_tap_p0.first);
    w_push_p0 = w_tap_p0;
    w_push_p0.act   = w_tap_p0.act & w_live;
    w_push_p0.first = w_tap_p0.first & w_live;
`ifdef TEST_PATTERN_EN
    w_push_p0.pat   = bus.test_mode;
    w_rd_req        = w_push_p0.act & ~bus.test_mode;
`else
    w_rd_req        = w_push_p0.act;
`endif
    w_tail    = r_dl[STAGES-1];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state       <= IDLE;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_blank_n     <= 1'b0;
      r_rgb         <= '0;
      r_rd_en       <= 1'b0;
      r_rd_addr     <= '0;
      r_frame_start <= 1'b0;
      r_range_err   <= 1'b0;
      for (int i = 0; i < STAGES; i++) r_dl[i] <= idle_tap();
    end else if (!bus.enable) begin
      r_state       <= IDLE;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_blank_n     <= 1'b0;
      r_rgb         <= '0;
      r_rd_en       <= 1'b0;
      r_rd_addr     <= '0;
      r_frame_start <= 1'b0;
      for (int i = 0; i < STAGES; i++) r_dl[i] <= idle_tap();
    end else begin
      r_rd_en       <= 1'b0;
      r_frame_start <= 1'b0;
      if (bus.pixel_clk) begin
        if (w_oor) r_range_err <= 1'b1;
        case (r_state)
          IDLE: r_state <= SYNCING;
          default: begin
            // stage 0: decoded pixel enters the latency-matching delay line
            r_dl[0] <= w_push_p0;
            for (int i = 1; i < STAGES; i++) r_dl[i] <= r_dl[i-1];
            // output stage: tail meets the read data returned for it
            r_hsync       <= w_tail.hs;
            r_vsync       <= w_tail.vs;
            r_blank_n     <= w_tail.act;
            r_rgb         <= pixel_out(w_tail, bus.rd_data);
            r_frame_start <= w_tail.first && (r_state == ACTIVE);
            if (w_live) r_state <= ACTIVE;
            if (w_rd_req) begin
              r_rd_en   <= 1'b1;
              r_rd_addr <= bus.counter_in_addr;
            end
          end
        endcase
      end
    end
  end

  assign bus.hsync       = r_hsync;
  assign bus.vsync       = r_vsync;
  assign bus.blank_n     = r_blank_n;
  assign bus.rgb_out     = r_rgb;
  assign bus.rd_en       = r_rd_en;
  assign bus.rd_addr     = r_rd_addr;
  assign bus.frame_start = r_frame_start;
  assign bus.range_err   = r_range_err;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Randomized bench for vga_sync_gen on a reduced raster, checked against a
// per-strobe history model of the display rules.
module tb_vga_sync_gen;

  localparam int H_ACTIVE = 16;
  localparam int H_FP     = 2;
  localparam int H_SYNC   = 4;
  localparam int H_TOTAL  = 26;
  localparam int V_ACTIVE = 5;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 2;
  localparam int V_TOTAL  = 10;
  localparam int MEM_LAT  = 2;
  localparam int DATA_W   = 8;
  localparam int LAT      = MEM_LAT + 1;
  localparam int HMAX     = 8192;

  logic clk   = 1'b0;
  logic n_rst = 1'b1;
  always #5 clk = ~clk;

  vga_sync_gen_if #(.DATA_W(DATA_W)) bus ();

  vga_sync_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_TOTAL(H_TOTAL),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_TOTAL(V_TOTAL),
    .MEM_LAT(MEM_LAT), .DATA_W(DATA_W)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus.slave)
  );

  int n_chk = 0;
  int n_err = 0;

  int  cur_col, cur_row, sidx, sess, mode, guard;
  bit  force_oor;
  bit  h_hs [HMAX];
  bit  h_vs [HMAX];
  bit  h_act[HMAX];
  bit  h_first[HMAX];
  int  h_sess[HMAX];
  bit  req_v[HMAX];
  logic [19:0] req_a[HMAX];

  logic e_hs, e_vs, e_bn, e_fs, e_rd, e_err;
  logic [7:0]  e_rgb;
  logic [19:0] e_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset_outputs();
    e_hs = 1'b1; e_vs = 1'b1; e_bn = 1'b0; e_rgb = 8'h00;
    e_fs = 1'b0; e_rd = 1'b0; e_addr = 20'h0;
  endtask

  task automatic check_all();
    chk("hsync",       32'(bus.hsync),       32'(e_hs));
    chk("vsync",       32'(bus.vsync),       32'(e_vs));
    chk("blank_n",     32'(bus.blank_n),     32'(e_bn));
    chk("rgb_out",     32'(bus.rgb_out),     32'(e_rgb));
    chk("frame_start", 32'(bus.frame_start), 32'(e_fs));
    chk("rd_en",       32'(bus.rd_en),       32'(e_rd));
    chk("range_err",   32'(bus.range_err),   32'(e_err));
    if (e_rd) chk("rd_addr", 32'(bus.rd_addr), 32'(e_addr));
  endtask

  // One clock: drive at negedge, predict the post-edge outputs, check after the edge.
  task automatic cycle(input bit strobe);
    int  c, r, k;
    bit  in_rng, act, hs, vs, live;
    @(negedge clk);
    if (sidx >= HMAX - 1) begin
      $display("FAIL strobe_budget: got %0d expected below %0d", sidx, HMAX - 1);
      $fatal(1, "strobe history exhausted");
    end
    c = force_oor ? 900 : cur_col;
    r = cur_row;
    k = sidx - LAT;
    bus.pixel_clk = strobe;
    if (strobe) begin
      bus.counter_in_col  = 10'(c);
      bus.counter_in_row  = 10'(r);
      bus.counter_in_addr = 20'(r * H_TOTAL + c);
      if (k >= 0 && req_v[k]) bus.rd_data = req_a[k][7:0];
      else                    bus.rd_data = 8'($urandom);
    end else begin
      bus.counter_in_col  = 10'($urandom_range(0, 1023));
      bus.counter_in_row  = 10'($urandom_range(0, 1023));
      bus.counter_in_addr = 20'($urandom);
      bus.rd_data         = 8'($urandom);
    end

    e_rd = 1'b0;
    e_fs = 1'b0;
    if (strobe) h_sess[sidx] = -1;
    if (!bus.enable) begin
      mode = 0;
      sess++;
      model_reset_outputs();
    end else if (strobe) begin
      in_rng = (c < H_TOTAL) && (r < V_TOTAL);
      if (!in_rng) e_err = 1'b1;
      if (mode == 0) begin
        mode = 1;
      end else begin
        act  = in_rng && (c < H_ACTIVE) && (r < V_ACTIVE);
        hs   = !(in_rng && c >= H_ACTIVE + H_FP && c < H_ACTIVE + H_FP + H_SYNC);
        vs   = !(in_rng && r >= V_ACTIVE + V_FP && r < V_ACTIVE + V_FP + V_SYNC);
        live = (mode == 2) || (c == 0 && r == 0);
        if (live) mode = 2;
        h_hs[sidx]    = hs;
        h_vs[sidx]    = vs;
        h_act[sidx]   = act && live;
        h_first[sidx] = live && c == 0 && r == 0;
        h_sess[sidx]  = sess;
        e_rd   = act && live;
        e_addr = bus.counter_in_addr;
        if (k >= 0 && h_sess[k] == sess) begin
          e_hs  = h_hs[k];
          e_vs  = h_vs[k];
          e_bn  = h_act[k];
          e_rgb = h_act[k] ? bus.rd_data : 8'h00;
          e_fs  = h_first[k];
        end else begin
          e_hs = 1'b1; e_vs = 1'b1; e_bn = 1'b0; e_rgb = 8'h00;
        end
      end
    end

    @(posedge clk);
    #1;
    check_all();
    if (strobe) begin
      req_v[sidx] = bus.rd_en;
      req_a[sidx] = bus.rd_addr;
      sidx++;
      cur_col++;
      if (cur_col == H_TOTAL) begin
        cur_col = 0;
        cur_row++;
        if (cur_row == V_TOTAL) cur_row = 0;
      end
    end
  endtask

  task automatic run(input int n, input bit dense);
    for (int i = 0; i < n; i++) cycle(dense ? 1'b1 : ($urandom_range(0, 2) != 0));
  endtask

  initial begin
    bus.enable = 1'b0;
    bus.pixel_clk = 1'b0;
    bus.counter_in_col = '0;
    bus.counter_in_row = '0;
    bus.counter_in_addr = '0;
    bus.rd_data = '0;
`ifdef TEST_PATTERN_EN
    bus.test_mode = 1'b0;
`endif
    cur_col = 10; cur_row = 2;
    sidx = 0; sess = 1; mode = 0; force_oor = 1'b0;
    e_err = 1'b0;
    model_reset_outputs();

    #2 n_rst = 1'b0;
    #1 check_all();
    chk("rd_addr_rst", 32'(bus.rd_addr), 32'h0);
    @(negedge clk);
    n_rst = 1'b1;

    run(4, 1'b0);
    bus.enable = 1'b1;
    run(700, 1'b0);

    force_oor = 1'b1;
    cycle(1'b1);
    force_oor = 1'b0;
    run(40, 1'b0);

    bus.enable = 1'b0;
    run(6, 1'b0);
    guard = 0;
    while (!(cur_col == 8 && cur_row == 3) && guard < 2000) begin
      cycle($urandom_range(0, 2) != 0);
      guard++;
    end
    chk("pos_wait", 32'(guard < 2000), 32'h1);
    bus.enable = 1'b1;
    run(600, 1'b0);

    @(posedge clk);
    #3 n_rst = 1'b0;
    #1;
    mode = 0;
    sess++;
    e_err = 1'b0;
    model_reset_outputs();
    check_all();
    @(negedge clk);
    bus.pixel_clk = 1'b0;
    @(posedge clk);
    #1 check_all();
    @(negedge clk);
    n_rst = 1'b1;

    run(500, 1'b0);
    run(150, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
